// File: rtl/color_batch_unpacker.sv
// Unpacks one BATCH_SIZE-color batch per handshake into a one-color-per-cycle valid/ready stream.
// Optional underrun counter port: define COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN.
module color_batch_unpacker #(
    parameter int BATCH_SIZE = 8
) (
    input  logic                    I_rgb_clk,
    input  logic                    I_rst_n,
    input  logic [8*BATCH_SIZE-1:0] I_batch_color,
    input  logic                    I_batch_valid,
    output logic                    O_batch_ready,
    output logic [7:0]              O_color,
    output logic                    O_color_valid,
    input  logic                    I_color_ready,
    output logic                    O_color_last
`ifdef COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             O_underrun_cnt
`endif
);

    localparam int IDX_W = $clog2(BATCH_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [8*BATCH_SIZE-1:0] r_active;
    logic [8*BATCH_SIZE-1:0] r_pending;
    logic [8*BATCH_SIZE-1:0] w_active_nxt;
    logic [8*BATCH_SIZE-1:0] w_pending_nxt;
    logic [IDX_W-1:0]        r_index;
    logic [IDX_W-1:0]        w_index_nxt;
    logic [7:0]              r_color;
    logic                    r_batch_ready;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_last_xfer;

    assign O_color_valid = (r_state != ST_EMPTY);
    assign O_color_last  = (r_index == LAST_IDX) && O_color_valid;
    assign O_color       = r_color;
    assign O_batch_ready = r_batch_ready;

    assign w_accept    = I_batch_valid && r_batch_ready;
    assign w_xfer      = O_color_valid && I_color_ready;
    assign w_last_xfer = w_xfer && (r_index == LAST_IDX);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_index_nxt   = r_index;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_active_nxt = I_batch_color;
                    w_index_nxt  = '0;
                    w_state_nxt  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_last_xfer) begin
                    w_index_nxt = '0;
                    if (w_accept) begin
                        w_active_nxt = I_batch_color;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end else begin
                    if (w_xfer) begin
                        w_index_nxt = r_index + IDX_W'(1);
                    end
                    if (w_accept) begin
                        w_pending_nxt = I_batch_color;
                        w_state_nxt   = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // Ready is low here, so only the emitting side can move.
                if (w_last_xfer) begin
                    w_active_nxt = r_pending;
                    w_index_nxt  = '0;
                    w_state_nxt  = ST_ACTIVE;
                end else if (w_xfer) begin
                    w_index_nxt = r_index + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // NOTE: the batch registers are reset too, so discarded data never leaks out after reset.
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state       <= ST_EMPTY;
            r_active      <= '0;
            r_pending     <= '0;
            r_index       <= '0;
            r_color       <= '0;
            r_batch_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_active      <= w_active_nxt;
            r_pending     <= w_pending_nxt;
            r_index       <= w_index_nxt;
            r_color       <= w_active_nxt[{w_index_nxt, 3'b000} +: 8];
            r_batch_ready <= (w_state_nxt != ST_FULL);
        end
    end

`ifdef COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN
    logic        r_seen_accept;
    logic [15:0] r_underrun_cnt;

    assign O_underrun_cnt = r_underrun_cnt;

    // Idle cycles before the first batch are start-up, not underruns.
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_seen_accept  <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_seen_accept <= 1'b1;
            end
            if (r_seen_accept && I_color_ready && !O_color_valid &&
                (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_color_batch_unpacker.sv
// Directed testbench for color_batch_unpacker with BATCH_SIZE=8.
// Exercises the underrun counter when COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN is defined.
module tb_color_batch_unpacker;

    localparam int BS = 8;

    logic            I_rgb_clk;
    logic            I_rst_n;
    logic [8*BS-1:0] I_batch_color;
    logic            I_batch_valid;
    logic            O_batch_ready;
    logic [7:0]      O_color;
    logic            O_color_valid;
    logic            I_color_ready;
    logic            O_color_last;
`ifdef COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN
    logic [15:0]     O_underrun_cnt;
`endif

    color_batch_unpacker #(.BATCH_SIZE(BS)) dut (
        .I_rgb_clk     (I_rgb_clk),
        .I_rst_n       (I_rst_n),
        .I_batch_color (I_batch_color),
        .I_batch_valid (I_batch_valid),
        .O_batch_ready (O_batch_ready),
        .O_color       (O_color),
        .O_color_valid (O_color_valid),
        .I_color_ready (I_color_ready),
        .O_color_last  (O_color_last)
`ifdef COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN
        ,
        .O_underrun_cnt(O_underrun_cnt)
`endif
    );

    initial I_rgb_clk = 1'b0;
    always #5 I_rgb_clk = ~I_rgb_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    bit toggle_mode = 0;

    logic [8*BS-1:0] src_q[$];
    logic [7:0]      got_q[$];
    logic            last_q[$];
    int              cyc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: samples handshakes, advances one rising edge, returns at the next falling edge.
    task automatic tick();
        logic       acc, xf, stall;
        logic [7:0] prev_color;
        logic       prev_last;
        acc        = I_batch_valid & O_batch_ready;
        xf         = O_color_valid & I_color_ready;
        stall      = O_color_valid & ~I_color_ready;
        prev_color = O_color;
        prev_last  = O_color_last;
        if (xf) begin
            got_q.push_back(O_color);
            last_q.push_back(O_color_last);
            cyc_q.push_back(cyc);
        end
        @(posedge I_rgb_clk);
        @(negedge I_rgb_clk);
        cyc++;
        if (stall) begin
            check("stall_color", O_color, prev_color);
            check("stall_last", O_color_last, prev_last);
        end
        if (acc) begin
            n_acc++;
            void'(src_q.pop_front());
            if (src_q.size() > 0) I_batch_color = src_q[0];
            else I_batch_valid = 1'b0;
        end
        if (toggle_mode) I_color_ready = ~I_color_ready;
    endtask

    task automatic push_batch(input logic [7:0] base);
        logic [8*BS-1:0] v;
        for (int k = 0; k < BS; k++) v[8*k +: 8] = base + 8'(k);
        src_q.push_back(v);
        if (src_q.size() == 1) begin
            I_batch_color = v;
            I_batch_valid = 1'b1;
        end
    endtask

    task automatic drain(input int n, input int budget);
        int b;
        b = 0;
        while (got_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (got_q.size() < n) check("drain_timeout", got_q.size(), n);
    endtask

    task automatic expect_stream(input string tag, input logic [7:0] base, input int n, input bit gapchk);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({tag, "_color"}, got_q[i], base + 8'(i));
            check({tag, "_last"}, last_q[i], (i % BS) == BS - 1);
            if (gapchk && i > 0) check({tag, "_gap"}, cyc_q[i] - cyc_q[i-1], 1);
        end
        got_q.delete();
        last_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        I_rst_n       = 1'b0;
        I_batch_color = '0;
        I_batch_valid = 1'b0;
        I_color_ready = 1'b0;

        // Reset state and ready rising one edge after release
        @(negedge I_rgb_clk);
        check("rst_color", O_color, 8'h00);
        check("rst_valid", O_color_valid, 1'b0);
        check("rst_last", O_color_last, 1'b0);
        check("rst_ready", O_batch_ready, 1'b0);
        @(negedge I_rgb_clk);
        I_rst_n = 1'b1;
        check("rel_ready0", O_batch_ready, 1'b0);
        tick();
        check("rel_ready1", O_batch_ready, 1'b1);

        // Single batch, continuous ready
        I_color_ready = 1'b1;
        push_batch(8'h00);
        tick();
        check("lat_valid", O_color_valid, 1'b1);
        check("lat_color", O_color, 8'h00);
        drain(8, 20);
        check("single_after_valid", O_color_valid, 1'b0);
        expect_stream("single", 8'h00, 8, 1'b1);

        // Four batches back-to-back, no bubble expected
        for (int b = 0; b < 4; b++) push_batch(8'(8 * b));
        drain(32, 80);
        expect_stream("b2b", 8'h00, 32, 1'b1);
        check("b2b_after_valid", O_color_valid, 1'b0);

        // Consumer stalled: pending fills, third batch must wait
        I_color_ready = 1'b0;
        n_acc = 0;
        for (int b = 0; b < 3; b++) push_batch(8'(8 * b));
        repeat (4) tick();
        check("stall_acc", n_acc, 2);
        check("stall_ready", O_batch_ready, 1'b0);
        check("stall_valid", O_color_valid, 1'b1);
        check("stall_c0", O_color, 8'h00);
        I_color_ready = 1'b1;
        drain(24, 80);
        expect_stream("stall", 8'h00, 24, 1'b0);

        // Ready toggling across two batches
        toggle_mode = 1;
        push_batch(8'h40);
        push_batch(8'h48);
        drain(16, 100);
        toggle_mode = 0;
        I_color_ready = 1'b1;
        expect_stream("toggle", 8'h40, 16, 1'b0);

        // Reset in the middle of a batch
        push_batch(8'h80);
        drain(4, 20);
        expect_stream("pre_rst", 8'h80, 4, 1'b1);
        #2;
        I_rst_n = 1'b0;
        #1;
        check("mid_rst_color", O_color, 8'h00);
        check("mid_rst_valid", O_color_valid, 1'b0);
        check("mid_rst_last", O_color_last, 1'b0);
        check("mid_rst_ready", O_batch_ready, 1'b0);
        @(negedge I_rgb_clk);
        I_rst_n = 1'b1;
        check("mid_rel_ready0", O_batch_ready, 1'b0);
        tick();
        check("mid_rel_ready1", O_batch_ready, 1'b1);
        push_batch(8'h90);
        drain(8, 20);
        expect_stream("post_rst", 8'h90, 8, 1'b1);

`ifdef COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN
        // Underrun counter: 10 idle ready cycles after one drained batch, then saturation
        I_color_ready = 1'b0;
        I_rst_n = 1'b0;
        @(negedge I_rgb_clk);
        I_rst_n = 1'b1;
        tick();
        check("ur_zero", O_underrun_cnt, 16'd0);
        push_batch(8'hA0);
        tick();
        I_color_ready = 1'b1;
        drain(8, 20);
        expect_stream("ur_batch", 8'hA0, 8, 1'b1);
        check("ur_after_drain", O_underrun_cnt, 16'd0);
        repeat (10) tick();
        check("ur_ten", O_underrun_cnt, 16'd10);
        force dut.r_underrun_cnt = 16'hFFFF;
        tick();
        release dut.r_underrun_cnt;
        repeat (3) tick();
        check("ur_sat", O_underrun_cnt, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/color_batch_unpacker.md
Name: color_batch_unpacker

Overview:
Inverse of the color batch packer. It accepts one packed batch of BATCH_SIZE 8-bit color values per handshake and emits them one color per cycle on a valid/ready stream. Downstream consumers are the per-matrix serial drivers. A one-deep pending register allows batches to be accepted back-to-back, so a continuously ready consumer sees no bubble between batches.

Parameters:
BATCH_SIZE, 8, number of 8-bit colors per batch; legal range 2..64.
IDX_W, $clog2(BATCH_SIZE), width of the internal byte index; derived, not overridden.

Ports:
I_rgb_clk  in  1  single clock for all logic.
I_rst_n  in  1  asynchronous active-low reset.
I_batch_color  in  8*BATCH_SIZE  packed batch; color k sits at bits [8k+7:8k]; color 0 is emitted first.
I_batch_valid  in  1  batch on I_batch_color is valid.
O_batch_ready  out  1  registered; block can accept a batch this cycle.
O_color  out  8  current color.
O_color_valid  out  1  O_color is valid.
I_color_ready  in  1  consumer accepts O_color this cycle.
O_color_last  out  1  high together with the final color (index BATCH_SIZE-1) of a batch.

Behaviour:
- Reset (I_rst_n low, asynchronous): O_color=0, O_color_valid=0, O_color_last=0, O_batch_ready=0; index=0; both batch registers are cleared; state=EMPTY. In-flight data is discarded with no partial completion. O_batch_ready rises on the first clock edge after reset release.
- Handshake and transfer definitions:
  - Batch accept = I_batch_valid & O_batch_ready.
  - Color transfer = O_color_valid & I_color_ready.
- Storage: active register (being emitted) plus pending register.
- States:
  - EMPTY: no active batch. Accept loads the active register, sets index=0, goes to ACTIVE.
  - ACTIVE: active batch loaded, pending register empty.
  - FULL: active and pending registers both loaded.
- Transitions out of ACTIVE:
  - Accept without a last-color transfer: batch goes to pending; state goes to FULL.
  - Last-color transfer plus accept in the same cycle: incoming batch loads the active register directly; index=0; state stays ACTIVE; no bubble.
  - Last-color transfer with no accept: state goes to EMPTY; O_color_valid drops next cycle.
- Transitions out of FULL:
  - Last-color transfer: pending moves to active; index=0; state goes to ACTIVE.
  - Accept cannot occur in FULL.
- O_batch_ready (registered) = 1 iff the next state is not FULL.
- Output rules:
  - O_color = active[index], registered.
  - O_color_valid = state != EMPTY.
  - O_color_last = (index == BATCH_SIZE-1) & O_color_valid.
- Latency: batch accepted at edge N from EMPTY gives O_color = color 0 with O_color_valid=1 after edge N.
- Index: increments by 1 on each color transfer. It wraps to 0 after BATCH_SIZE-1 and never exceeds BATCH_SIZE-1.
- Stall: while O_color_valid & !I_color_ready, O_color, O_color_last and index hold stable.
- I_batch_valid while O_batch_ready=0: ignored; the batch is not captured and the source must hold it.

Optional Feature:
Macro COLOR_BATCH_UNPACKER_UNDERRUN_CNT_EN.
- Defined:
  - Adds port O_underrun_cnt, out, 16 bits.
  - Saturating counter that increments each cycle where I_color_ready=1 and O_color_valid=0, counted only after the first batch accept since reset.
  - Holds at 0xFFFF once saturated; resets to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single batch, bytes 0x00..0x07 (color k = k), I_color_ready=1 -> O_color 0x00..0x07 on 8 consecutive cycles starting one cycle after accept; O_color_last only with 0x07; O_color_valid low afterwards.
- Four batches offered back-to-back (colors 0..31), I_color_ready=1 -> 32 consecutive valid cycles with values 0..31; no gap; O_color_last with 7, 15, 23, 31.
- Batches held valid and I_color_ready low -> second batch accepted into pending, then O_batch_ready=0; third batch not captured; O_color=0x00 held stable; once ready is released, all 24 colors appear in order.
- I_color_ready toggling 1,0,1,0 -> O_color stable during each stall cycle; order and count preserved; index wraps correctly.
- Assert I_rst_n low mid-batch, after color 3 is emitted -> all outputs 0 immediately; after release, O_batch_ready=1 one edge later; a new batch emits from its color 0.
- With the macro defined: after one batch drains, hold I_color_ready=1 for 10 idle cycles -> O_underrun_cnt=10; force it to 0xFFFF -> it stays at 0xFFFF.
